// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: an n-bit operation processed k bits per clock through one registered carry.
// Optional signed saturation of the result is enabled by defining SEQ_ADDSUB_SAT_EN.
module seq_addsub #(
  parameter int n = 32,
  parameter int k = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NCH = n / k;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if ((n % k) != 0) begin : g_width_check
    $error("seq_addsub: n must be a multiple of k");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [n-1:0]  a_q, a_d;
  logic [n-1:0]  b_q, b_d;
  logic [n-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [k-1:0]  a_chunk, b_chunk;
  logic [k:0]    chunk_sum;
  logic          ovf_last;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    a_chunk   = a_q[int'(cnt_q)*k +: k];
    b_chunk   = b_q[int'(cnt_q)*k +: k];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{k{1'b0}}, carry_q};
    // Carry into the MSB is recovered as a^b^sum at that bit; overflow is it XOR carry out.
    ovf_last  = a_q[n-1] ^ b_q[n-1] ^ chunk_sum[k-1] ^ chunk_sum[k];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[int'(cnt_q)*k +: k] = chunk_sum[k-1:0];
        carry_d = chunk_sum[k];
        if (cnt_q == LAST) begin
          cout_d  = chunk_sum[k];
          ovf_d   = ovf_last;
          state_d = DONE;
`ifdef SEQ_ADDSUB_SAT_EN
          if (ovf_last) begin
            sum_d = a_q[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench for seq_addsub at n=32, k=8.
// Expected sums follow SEQ_ADDSUB_SAT_EN when the bench is compiled with it.
module tb_seq_addsub;

  localparam int N = 32;
  localparam int K = 8;
  localparam int LAT = N / K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout, ovf;

  int n_vec = 0;
  int n_bad = 0;

  seq_addsub #(.n(N), .k(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    n_vec++;
    if (!out_valid) begin
      n_bad++;
      $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, cycles);
    end
  endtask

  // Present one operation from IDLE, check latency, result and the output handshake.
  task automatic run_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic tcin, input logic tsub,
                        input logic [N-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int cyc;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    wait_valid(name, cyc);
    n_vec++;
    if (cyc != LAT) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
    end
    n_vec++;
    if (sum !== exp_sum) begin
      n_bad++; $display("FAIL %s sum: got %h want %h", name, sum, exp_sum);
    end
    n_vec++;
    if (cout !== exp_cout) begin
      n_bad++; $display("FAIL %s cout: got %b want %b", name, cout, exp_cout);
    end
    n_vec++;
    if (ovf !== exp_ovf) begin
      n_bad++; $display("FAIL %s ovf: got %b want %b", name, ovf, exp_ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (sum !== '0) begin n_bad++; $display("FAIL reset sum: got %h want 0", sum); end
    n_vec++;
    if (cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset flags: cout=%b ovf=%b want 0/0", cout, ovf);
    end
  endtask

  task automatic test_add_carry();
    run_op("add_chunk_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
  endtask

  task automatic test_ripple();
    run_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("cin_only",    32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
`ifdef SEQ_ADDSUB_SAT_EN
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
  endtask

  task automatic test_sub_borrow();
    run_op("sub_borrow",    32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_borrow_in", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    logic stable;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("bp_first", cyc);
    // New operands offered while the result is held.
    a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h2345_6789 || cout !== 1'b0 || ovf !== 1'b0)
        stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_bad++; $display("FAIL bp_hold: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b want 1/0/23456789/0/0",
                        out_valid, in_ready, sum, cout, ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    // in_valid is still high, so the pending operands are taken at this edge.
    tick();
    in_valid = 1'b0;
    a = '0; b = '0;
    wait_valid("bp_second", cyc);
    n_vec++;
    if (cyc != LAT || sum !== 32'd3 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL bp_second: cycles=%0d sum=%h cout=%b ovf=%b want %0d/00000003/0/0",
                        cyc, sum, cout, ovf, LAT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_vec++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset outputs: sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_bad++; $display("FAIL mid_reset emitted: out_valid rose after abort, want 0");
    end
    run_op("after_reset", 32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b1, 32'hDEAD_BEDE, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    test_reset();
    test_add_carry();
    test_ripple();
    test_overflow();
    test_sub_borrow();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the combinational catalog adder.
- Processes an n-bit operation k bits per clock through one registered carry, trading latency for a short carry chain.
- Uses a valid/ready handshake on both input and output, so it can sit between datapath stages in the catalog CPU datapath and ALU experiments.
- Reports carry/borrow and signed overflow.

Parameters:
- n, 32, operand/result width in bits.
- k, 8, chunk width added per cycle. n must be a multiple of k, else elaboration error. k == n gives a single-chunk pass.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  n  operand A
- b  input  n  operand B
- cin  input  1  carry-in for add; borrow-in for subtract
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  n  result
- cout  output  1  carry-out. For sub, 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (rst high at a rising edge): state IDLE, chunk counter 0, carry register 0, out_valid 0, sum 0, cout 0, ovf 0. in_ready is 1 in the cycle after the reset edge.
- Reset has priority over every other event. Asserted in BUSY or DONE, it aborts the operation and no result is emitted.
- Arithmetic:
  - sub=0: sum = a + b + cin
  - sub=1: sum = a + ~b + ~cin, i.e. a - b - cin
  - Result is mod 2^n.
  - cout is the carry out of bit n-1.
  - ovf = carry into MSB XOR carry out of MSB.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a; latch b, inverted if sub; set carry register = (sub ? ~cin : cin); latch sub; counter=0; go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle: chunk i (bits i*k+k-1 : i*k) = A_i + B_i + carry. Write into sum bits of chunk i; update carry register.
  - On the final chunk (i = n/k-1): capture cout and ovf, then go to DONE.
  - Otherwise counter increments.
  - Inputs are ignored.
- Latency: accepted at edge T, out_valid high after edge T + n/k. Example: n=32, k=8 gives 4 cycles.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready high: go to IDLE; out_valid falls at that edge.
  - No new operand is accepted in the same cycle; back-to-back throughput is one result per n/k + 2 cycles.
  - out_ready low: stay in DONE indefinitely.
- sum, cout and ovf are defined only while out_valid=1. Partial chunks may be visible on sum during BUSY; benches must not check them.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- The counter width is max(1, $clog2(n/k)). The counter never wraps, because the FSM leaves BUSY at the last chunk.

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN
- Defined: signed saturation.
  - When ovf=1 at the final chunk, sum is replaced by the signed max (0 followed by ones) if the A MSB is 0, or the signed min (1 followed by zeros) if the A MSB is 1.
  - ovf and cout are still reported unmodified.
  - The saturation mux is applied at the BUSY->DONE transition, so latency is unchanged.
- Undefined: wrap-around result only; no saturation logic synthesised.

Test Plan (n=32, k=8):
- Add with inter-chunk carry: a=0x000000FF, b=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Full-width carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Also a=0, b=0, cin=1 -> sum=0x00000001.
- Signed overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0 (with SAT_EN: sum=0x7FFFFFFF). Also a=0x80000000, b=1, sub=1, cin=0 -> sum=0x7FFFFFFF, ovf=1, cout=1 (with SAT_EN: sum=0x80000000).
- Subtract with borrow: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=7, b=5, sub=1, cin=1 -> sum=0x00000001, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, sum, cout and ovf stable; in_ready=0; new operands not taken. Raise out_ready -> single handshake; in_ready=1 the next cycle; second operation then completes correctly.
- Reset mid-operation: assert rst for one edge during BUSY chunk 2 -> after that edge state is IDLE, out_valid=0, in_ready=1, sum=0, cout=0, ovf=0; no result emitted; the next operation computes correctly.
